pipe_ctrl_unit: RTL

Parametrised successor to the single-cycle-decode RISC-V controller. It decodes the D-stage instruction and holds the ID/EX control register internally, with stall/flush support. Optionally (ENABLE_M) it sequences multi-cycle RV32M operations through a handshake with an external multiply/divide unit. An illegal opcode reaching E halts the core with a sticky `done`. It sits between the IF/ID register and the EX stage of the pipelined datapath and replaces the combinational controller plus the separate control fields of the ID/EX register.

---
 rtl/pipe_ctrl_unit.sv | 269 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit
//   Pipelined RISC-V control unit. Decodes the D-stage instruction, holds the
//   ID/EX control register, and sequences optional RV32M operations through a
//   start/done handshake with an external multiply/divide unit. An illegal
//   instruction reaching E halts the core until reset.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   instr_d, valid_d    D-stage instruction and its valid flag (0 = bubble)
//   stall_e, flush_e    hazard-unit controls for the E register (flush wins)
//   mdu_done            one-cycle pulse from the MDU: result ready
//   ImmSrcD             combinational immediate select for the D stage
//   *E outputs          registered E-stage control fields
//   mdu_start           one-cycle pulse launching the M op held in E
//   stall_req           freeze request for the PC and IF/ID register
//   done                sticky halt flag
//
// ALU_CTRL_W must be >= 3, and >= 4 when ENABLE_M = 1.
module pipe_ctrl_unit #(
    parameter int ENABLE_M   = 0,
    parameter int ALU_CTRL_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           instr_d,
    input  logic                  valid_d,
    input  logic                  stall_e,
    input  logic                  flush_e,
    input  logic                  mdu_done,
    output logic [2:0]            ImmSrcD,
    output logic                  RegWriteE,
    output logic                  MemWriteE,
    output logic                  ALUSrcE,
    output logic                  JumpE,
    output logic                  JumpSelE,
    output logic [1:0]            ResultSrcE,
    output logic                  BeqE,
    output logic                  BneE,
    output logic                  BltE,
    output logic                  BgeE,
    output logic [ALU_CTRL_W-1:0] ALUControlE,
    output logic                  mdu_start,
    output logic                  stall_req,
    output logic                  done
);

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_AND   = 4'd2;
    localparam logic [3:0] ALU_OR    = 4'd3;
    localparam logic [3:0] ALU_PASSB = 4'd4;
    localparam logic [3:0] ALU_SLT   = 4'd5;
    localparam logic [3:0] ALU_XOR   = 4'd7;

    typedef enum logic [1:0] {RUN, MDU_WAIT, HALT} state_t;

    typedef struct packed {
        logic                  reg_write;
        logic                  mem_write;
        logic                  alu_src;
        logic                  jump;
        logic                  jump_sel;
        logic [1:0]            result_src;
        logic                  beq;
        logic                  bne;
        logic                  blt;
        logic                  bge;
        logic [ALU_CTRL_W-1:0] alu_ctrl;
        logic                  illegal;
        logic                  is_md;
    } ectl_t;

    // Narrow/widen a 4-bit ALU code to the configured control width.
    function automatic logic [ALU_CTRL_W-1:0] alu_code(input logic [3:0] code);
        return ALU_CTRL_W'(code);
    endfunction

    function automatic logic [3:0] ri_alu(input logic [2:0] f3, input logic sub);
        case (f3)
            3'b000:  ri_alu = sub ? ALU_SUB : ALU_ADD;
            3'b111:  ri_alu = ALU_AND;
            3'b110:  ri_alu = ALU_OR;
            3'b100:  ri_alu = ALU_XOR;
            3'b010:  ri_alu = ALU_SLT;
            default: ri_alu = ALU_ADD;
        endcase
    endfunction

    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       unused_instr_bits;

    assign op = instr_d[6:0];
    assign f3 = instr_d[14:12];
    assign f7 = instr_d[31:25];
    assign unused_instr_bits = ^{instr_d[24:15], instr_d[11:7]};

    ectl_t  dec;
    ectl_t  e_d, e_q;
    logic   start_d;
    logic   mdu_start_q;
    logic   done_q;
    state_t state_q;
    logic   halted;

    // D-stage decode. An illegal word decodes to a bubble with only the
    // illegal marker set, so it never carries write enables into E.
    always_comb begin
        dec     = '0;
        ImmSrcD = 3'd0;
        case (op)
            OP_LW: begin
                dec.reg_write  = 1'b1;
                dec.alu_src    = 1'b1;
                dec.result_src = 2'd1;
            end
            OP_SW: begin
                ImmSrcD       = 3'd1;
                dec.alu_src   = 1'b1;
                dec.mem_write = 1'b1;
            end
            OP_R: begin
                dec.reg_write = 1'b1;
                if (f7 == 7'b0000001) begin
                    if (ENABLE_M != 0) begin
                        dec.is_md = 1'b1;
                        case (f3)
                            3'b000:  dec.alu_ctrl = alu_code(4'd8);
                            3'b001:  dec.alu_ctrl = alu_code(4'd9);
                            3'b100:  dec.alu_ctrl = alu_code(4'd10);
                            3'b110:  dec.alu_ctrl = alu_code(4'd11);
                            default: dec.illegal  = 1'b1;
                        endcase
                    end else begin
                        dec.illegal = 1'b1;
                    end
                end else begin
                    dec.alu_ctrl = alu_code(ri_alu(f3, f7 == 7'b0100000));
                end
            end
            OP_B: begin
                ImmSrcD      = 3'd2;
                dec.alu_ctrl = alu_code(ALU_SUB);
                case (f3)
                    3'b000:  dec.beq     = 1'b1;
                    3'b001:  dec.bne     = 1'b1;
                    3'b100:  dec.blt     = 1'b1;
                    3'b101:  dec.bge     = 1'b1;
                    default: dec.illegal = 1'b1;
                endcase
            end
            OP_I: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_ctrl  = alu_code(ri_alu(f3, 1'b0));
            end
            OP_JAL: begin
                ImmSrcD        = 3'd3;
                dec.reg_write  = 1'b1;
                dec.result_src = 2'd2;
                dec.jump       = 1'b1;
            end
            OP_JALR: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.jump      = 1'b1;
                dec.jump_sel  = 1'b1;
            end
            OP_LUI: begin
                ImmSrcD       = 3'd4;
                dec.reg_write = 1'b1;
                dec.alu_ctrl  = alu_code(ALU_PASSB);
            end
            default: dec.illegal = 1'b1;
        endcase
        if (!valid_d) begin
            dec = '0;
        end else if (dec.illegal) begin
            dec         = '0;
            dec.illegal = 1'b1;
        end
    end

    // Next E contents when the register is allowed to advance.
    always_comb begin
        e_d     = e_q;
        start_d = 1'b0;
        if (flush_e) begin
            e_d = '0;
        end else if (!stall_e) begin
            e_d     = dec;
            start_d = dec.is_md;
        end
    end

    // mdu_start_q marks the first cycle a fresh M op sits in E; a completed
    // M op held by stall_e afterwards does not set it again, so it is never
    // relaunched. The E register is held through the start cycle as well.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            e_q         <= '0;
            mdu_start_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            mdu_start_q <= 1'b0;
            case (state_q)
                RUN: begin
                    if (e_q.illegal) begin
                        state_q <= HALT;
                        done_q  <= 1'b1;
                    end else if (mdu_start_q && e_q.is_md) begin
                        state_q <= MDU_WAIT;
                    end else begin
                        e_q         <= e_d;
                        mdu_start_q <= start_d;
                    end
                end
                MDU_WAIT: begin
                    if (mdu_done) begin
                        state_q     <= RUN;
                        e_q         <= e_d;
                        mdu_start_q <= start_d;
                    end
                end
                HALT: begin
                    state_q <= HALT;
                end
                default: state_q <= RUN;
            endcase
        end
    end

    // The start cycle also stalls fetch: E is held, so D must not advance.
    always_comb begin
        case (state_q)
            RUN:      stall_req = mdu_start_q;
            MDU_WAIT: stall_req = ~mdu_done;
            HALT:     stall_req = 1'b1;
            default:  stall_req = 1'b0;
        endcase
    end

    assign halted      = (state_q == HALT);
    assign RegWriteE   = e_q.reg_write & ~halted;
    assign MemWriteE   = e_q.mem_write & ~halted;
    assign JumpE       = e_q.jump & ~halted;
    assign BeqE        = e_q.beq & ~halted;
    assign BneE        = e_q.bne & ~halted;
    assign BltE        = e_q.blt & ~halted;
    assign BgeE        = e_q.bge & ~halted;
    assign ALUSrcE     = e_q.alu_src;
    assign JumpSelE    = e_q.jump_sel;
    assign ResultSrcE  = e_q.result_src;
    assign ALUControlE = e_q.alu_ctrl;
    assign mdu_start   = mdu_start_q;
    assign done        = done_q;

endmodule
